sha256_block: RTL and testbench
===============================

SHA256_BLOCK -- requirements
Module: sha256_block

Interface
REQ-001 The block SHALL have no parameters; round count is fixed at 64 and word width at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 H_in  input  256  chaining value, H0 in bits [255:224] down to H7 in [31:0].
REQ-005 M_in  input  512  padded message block, W0 in bits [511:480] down to W15 in [31:0], big-endian.
REQ-006 input_valid  input  1  start request, sampled on rising clk.
REQ-007 H_out  output  256  updated chaining value, same word order as H_in.
REQ-008 output_valid  output  1  high while H_out holds a finished result.

Function
REQ-009 The block SHALL implement the FIPS 180-4 SHA-256 compression function, one round per clock.
REQ-010 States SHALL be IDLE, RUN and DONE; the state after reset SHALL be IDLE.
REQ-011 In IDLE or DONE, input_valid=1 at an edge SHALL latch H_in and M_in, load a..h from H_in, load the 16-word schedule window from M_in, clear the round counter, drop output_valid, and enter RUN.
REQ-012 In RUN, each edge SHALL execute round t (t=0..63) using K[t] and W[t].
REQ-013 W[t] for t>=16 SHALL be computed as sigma1(W[t-2])+W[t-7]+sigma0(W[t-15])+W[t-16] mod 2^32, produced by shifting a 16-word window.
REQ-014 On the edge executing round 63, H_out SHALL be registered as the latched H_in plus the new a..h, wordwise mod 2^32, output_valid SHALL go to 1, and the state SHALL go to DONE.
REQ-015 Latency: output_valid SHALL first be 1 after exactly 64 rising edges following the accepting edge.
REQ-016 In DONE, H_out and output_valid=1 SHALL hold until the next accepted input_valid.
REQ-017 input_valid during RUN SHALL be ignored, with no effect on the computation in progress.
REQ-018 H_in and M_in SHALL be don't-care after the accepting edge.
REQ-019 All additions SHALL be 32-bit modular with carries discarded.

Reset
REQ-020 While rst=0, the block SHALL be in IDLE with H_out=0, output_valid=0, round counter=0 and working registers=0, asynchronously.
REQ-021 Reset asserted during RUN SHALL abort the computation without producing a result.
REQ-022 After rst deasserts, the first edge with input_valid=1 SHALL be accepted.

Configuration
REQ-023 With macro SHA256_BUSY_EN defined, an extra output port busy (1 bit) SHALL be present; it is 1 exactly while in RUN and 0 in reset.
REQ-024 Without SHA256_BUSY_EN, the busy port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 A shared package sha256_pkg SHALL hold the 64-entry K round-constant table, the 8-word initial hash value (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), and the state enum.
REQ-026 SHA_IHV SHALL be a separate combinational sub-module with one output, IHV [255:0], that drives the package initial hash value in H_in word order.
REQ-027 sha256_block SHALL contain no sub-modules; Sigma and sigma functions SHALL be package functions.

Verification
REQ-028 "abc" padded block (61626380 00..00 00000018) with H_in=IHV, input_valid pulsed for 1 cycle -> output_valid rises after 64 edges, H_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-029 Empty-message block (80000000 00..00 00000000) with H_in=IHV -> H_out=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-030 "Joseph" block (4a6f7365 70688000 00..00 00000030) with H_in=IHV -> H_out equals software SHA-256("Joseph"), and output_valid=0 on edges 1..63 after acceptance.
REQ-031 Pulse input_valid again at round 30 with a different M_in -> result still equals the first message's digest, at the original cycle.
REQ-032 Assert rst at round 40, release it, then start "abc" -> output_valid=0 and H_out=0 during reset, followed by the correct "abc" digest 64 edges after the new start.
REQ-033 Back-to-back test: input_valid=1 in DONE -> output_valid drops on the next edge and the new digest appears 64 edges later.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM states, round constants, initial hash value
// and the Sigma/sigma/Ch/Maj helper functions.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [255:0] SHA_IHV_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/SHA_IHV.sv
// Drives the SHA-256 initial hash value, H0 in the top word, for callers
// that start a fresh digest.
module SHA_IHV
  import sha256_pkg::*;
(
  output logic [255:0] IHV
);

  assign IHV = SHA_IHV_INIT;

endmodule

// File: rtl/sha256_block.sv
// Iterative SHA-256 compression, one round per clock, 64 rounds per block.
// Define SHA256_BUSY_EN to expose a busy output that is high while in RUN.
module sha256_block
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] H_in,
  input  logic [511:0] M_in,
  input  logic         input_valid,
  output logic [255:0] H_out,
  output logic         output_valid
`ifdef SHA256_BUSY_EN
  ,
  output logic         busy
`endif
);

  state_e              state_q, state_d;
  logic [5:0]          rnd_q, rnd_d;
  logic [7:0][31:0]    wv_q, wv_d;     // a..h at index 0..7
  logic [7:0][31:0]    hlat_q, hlat_d;
  logic [15:0][31:0]   w_q, w_d;       // w_q[0] is W[t] for the current round
  logic [255:0]        hout_q, hout_d;
  logic                ovld_q, ovld_d;

  logic [31:0]         t1, t2;
  logic [7:0][31:0]    rnd_v;

  always_comb begin
    t1 = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[rnd_q] + w_q[0];
    t2 = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
    rnd_v = wv_q;
    rnd_v[0] = t1 + t2;
    for (int i = 1; i < 8; i++) rnd_v[i] = wv_q[i-1];
    rnd_v[4] = wv_q[3] + t1;
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    wv_d    = wv_q;
    hlat_d  = hlat_q;
    w_d     = w_q;
    hout_d  = hout_q;
    ovld_d  = ovld_q;
    case (state_q)
      ST_RUN: begin
        wv_d  = rnd_v;
        rnd_d = rnd_q + 6'd1;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        // Window slides so that w_q[15] always holds W[t+15]
        w_d[15] = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
        if (rnd_q == 6'd63) begin
          for (int i = 0; i < 8; i++) hout_d[255-32*i -: 32] = hlat_q[i] + rnd_v[i];
          ovld_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        if (input_valid) begin
          for (int i = 0; i < 8; i++) begin
            hlat_d[i] = H_in[255-32*i -: 32];
            wv_d[i]   = H_in[255-32*i -: 32];
          end
          for (int i = 0; i < 16; i++) w_d[i] = M_in[511-32*i -: 32];
          rnd_d   = '0;
          ovld_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      wv_q    <= '0;
      hlat_q  <= '0;
      w_q     <= '0;
      hout_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wv_q    <= wv_d;
      hlat_q  <= hlat_d;
      w_q     <= w_d;
      hout_q  <= hout_d;
      ovld_q  <= ovld_d;
    end
  end

  assign H_out        = hout_q;
  assign output_valid = ovld_q;

`ifdef SHA256_BUSY_EN
  assign busy = (state_q == ST_RUN);
`endif

endmodule

// File: tb/tb_sha256_block.sv
// Self-checking bench for sha256_block: known digests plus random blocks
// against a full-schedule SHA-256 compression model.
module tb_sha256_block;
  import sha256_pkg::K;

  localparam logic [255:0] IHV_REF   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] JOE_BLK   = {32'h4a6f7365, 32'h70688000, 416'h0, 32'h00000030};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] H_in = '0;
  logic [511:0] M_in = '0;
  logic         input_valid = 1'b0;
  logic [255:0] H_out;
  logic         output_valid;
  logic [255:0] ihv;
`ifdef SHA256_BUSY_EN
  logic         busy;
`endif

  always #5 clk = ~clk;

  SHA_IHV u_ihv (.IHV(ihv));

  sha256_block dut (
    .clk          (clk),
    .rst          (rst),
    .H_in         (H_in),
    .M_in         (M_in),
    .input_valid  (input_valid),
    .H_out        (H_out),
    .output_valid (output_valid)
`ifdef SHA256_BUSY_EN
    ,
    .busy         (busy)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4: expand all 64 schedule words, then run the rounds.
  function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    return {rand256(), rand256()};
  endfunction

  // Accept one block and watch all 64 following edges; optionally poke
  // input_valid mid-run with a different message that must be ignored.
  task automatic run_block(input string tag, input logic [255:0] h, input logic [511:0] m,
                           input bit interfere, input logic [255:0] exp);
    @(negedge clk);
    H_in = h; M_in = m; input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0; H_in = rand256(); M_in = rand512();
    chk({tag, "_vld_drop"}, output_valid, 0);
    for (int e = 1; e < 64; e++) begin
      @(posedge clk); #1;
      chk({tag, "_vld_low"}, output_valid, 0);
`ifdef SHA256_BUSY_EN
      chk({tag, "_busy"}, busy, 1);
`endif
      if (interfere && e == 30) begin input_valid = 1'b1; M_in = rand512(); H_in = rand256(); end
      if (interfere && e == 31) input_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "_vld_hi"}, output_valid, 1);
    chk({tag, "_digest"}, H_out, exp);
`ifdef SHA256_BUSY_EN
    chk({tag, "_busy_done"}, busy, 0);
`endif
  endtask

  initial begin
    logic [255:0] h;
    logic [511:0] m;
    #1;
    chk("rst_hout", H_out, 0);
    chk("rst_vld", output_valid, 0);
    chk("ihv", ihv, IHV_REF);
`ifdef SHA256_BUSY_EN
    chk("rst_busy", busy, 0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_block("abc", ihv, ABC_BLK, 1'b0, ABC_DIG);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_vld", output_valid, 1);
    chk("hold_digest", H_out, ABC_DIG);

    run_block("empty", ihv, EMPTY_BLK, 1'b0, EMPTY_DIG);
    run_block("joseph", ihv, JOE_BLK, 1'b0, ref_compress(IHV_REF, JOE_BLK));

    for (int k = 0; k < 4; k++) begin
      h = rand256(); m = rand512();
      run_block(k[0] ? "rand_poke" : "rand", h, m, k[0], ref_compress(h, m));
    end

    // Abort mid-run with reset, then a clean start must still work.
    @(negedge clk);
    H_in = rand256(); M_in = rand512(); input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_hout", H_out, 0);
    chk("abort_vld", output_valid, 0);
    @(posedge clk); #1;
    chk("abort_hout_edge", H_out, 0);
    chk("abort_vld_edge", output_valid, 0);
`ifdef SHA256_BUSY_EN
    chk("abort_busy", busy, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    run_block("abc_after_rst", ihv, ABC_BLK, 1'b0, ABC_DIG);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
